// File: rtl/uart_cmd_decoder_if.sv
// Command-decoder bus bundle: frame input, register write/read ports, response output.
// Latency: none (wiring only).
// Backpressure: resp_vld/resp_rdy handshake; in_vld has no ready and is dropped while busy.
// Ports (signals): in_data/in_vld (frame in), reg_wr_* (write strobe),
//   reg_rd_*/reg_rd_data (read strobe, data returns the next cycle),
//   resp_data/resp_vld/resp_rdy (status + payload out).
interface uart_cmd_decoder_if;
    logic [31:0] in_data;
    logic        in_vld;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_addr;
    logic [7:0]  reg_rd_data;
    logic [15:0] resp_data;
    logic        resp_vld;
    logic        resp_rdy;

    // Decoder side
    modport slave (
        input  in_data, in_vld, reg_rd_data, resp_rdy,
        output reg_wr_en, reg_wr_addr, reg_wr_data,
        output reg_rd_en, reg_rd_addr, resp_data, resp_vld
    );

    // Frame source / register file / transmitter side
    modport master (
        output in_data, in_vld, reg_rd_data, resp_rdy,
        input  reg_wr_en, reg_wr_addr, reg_wr_data,
        input  reg_rd_en, reg_rd_addr, resp_data, resp_vld
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes 4-byte command frames into register write/read strobes and returns an ACK/NAK response.
// Latency from in_vld: NAK resp at +2; write strobe +2, resp +3; read strobe +2, resp +4.
// Backpressure: response held stable until resp_rdy; frames arriving while busy are dropped and counted.
// Ports: clk, rstn (async active-low), bus (uart_cmd_decoder_if.slave),
//   busy (FSM not idle), err_cnt (saturating NAK count), ovf_cnt (saturating dropped-frame count).
module uart_cmd_decoder #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter logic [7:0] ACK    = 8'h5A,
    parameter logic [7:0] NAK    = 8'hEE
) (
    input  logic                clk,
    input  logic                rstn,
    uart_cmd_decoder_if.slave   bus,
    output logic                busy,
    output logic [7:0]          err_cnt,
    output logic [7:0]          ovf_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WRITE  = 3'd2,
        RDREQ  = 3'd3,
        RDWAIT = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] frame_q;
    logic        wr_en_q;
    logic [3:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        rd_en_q;
    logic [3:0]  rd_addr_q;
    logic        resp_vld_q;
    logic [15:0] resp_data_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  ovf_cnt_q;

    // Frame fields of the latched frame
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] sum;
    logic [7:0] err_code;

    assign b0  = frame_q[7:0];
    assign b1  = frame_q[15:8];
    assign b2  = frame_q[23:16];
    assign b3  = frame_q[31:24];
    assign sum = b0 + b1 + b2;

    // Error priority: header, then checksum, then reserved bits; 0 means frame is good
    always_comb begin
        err_code = 8'h00;
        if (b0 != HEADER) begin
            err_code = 8'h01;
        end else if (b3 != sum) begin
            err_code = 8'h02;
        end else if (b1[6:4] != 3'b000) begin
            err_code = 8'h03;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            err_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            // Strobes are single-cycle; only the transition into WRITE/RDREQ raises them
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;

            // Any frame outside IDLE is dropped, including the cycle RESP hands back to IDLE
            if (bus.in_vld && (state_q != IDLE) && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.in_vld) begin
                        frame_q <= bus.in_data;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (err_code != 8'h00) begin
                        resp_vld_q  <= 1'b1;
                        resp_data_q <= {err_code, NAK};
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        state_q <= RESP;
                    end else if (b1[7]) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= b1[3:0];
                        wr_data_q <= b2;
                        state_q   <= WRITE;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= b1[3:0];
                        state_q   <= RDREQ;
                    end
                end
                WRITE: begin
                    resp_vld_q  <= 1'b1;
                    resp_data_q <= {b2, ACK};
                    state_q     <= RESP;
                end
                RDREQ: begin
                    state_q <= RDWAIT;
                end
                RDWAIT: begin
                    // Read data is valid this cycle, one after the read strobe
                    resp_vld_q  <= 1'b1;
                    resp_data_q <= {bus.reg_rd_data, ACK};
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.resp_rdy) begin
                        resp_vld_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    resp_vld_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.reg_rd_addr = rd_addr_q;
    assign bus.resp_vld    = resp_vld_q;
    assign bus.resp_data   = resp_data_q;
    assign busy            = (state_q != IDLE);
    assign err_cnt         = err_cnt_q;
    assign ovf_cnt         = ovf_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed and random frames, scoreboard of expected strobes/responses.
// Latency and response stability are checked by a monitor decoupled from stimulus.
// Backpressure: resp_rdy driven high, random or low depending on the phase.
module tb_uart_cmd_decoder;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam logic [7:0] ACKB = 8'h5A;
    localparam logic [7:0] NAKB = 8'hEE;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;
    logic [7:0] ovf_cnt;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.HEADER(HDR), .ACK(ACKB), .NAK(NAKB)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = write strobe, 1 = read strobe, 2 = response
    typedef struct {
        int          kind;
        logic [15:0] dat;
        logic [3:0]  addr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   err_exp  = 0;
    int   ovf_exp  = 0;
    int   rdy_mode = 0;

    // Register file behind the decoder and the reference model's own copy of it
    logic [7:0] mem [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77, 8'h66, 8'h88,
                             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0F};
    logic [7:0] shadow [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77, 8'h66, 8'h88,
                                8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0F};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.reg_rd_en) bus.reg_rd_data <= mem[bus.reg_rd_addr];
        if (bus.reg_wr_en) mem[bus.reg_wr_addr] <= bus.reg_wr_data;
    end

    initial begin
        bus.resp_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.resp_rdy = 1'b1;
                1:       bus.resp_rdy = ($urandom_range(0, 9) < 7);
                default: bus.resp_rdy = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event, queue size %0d (cycle %0d)", nm, q.size(), cyc);
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic push_exp(input int kind, input logic [15:0] dat, input logic [3:0] addr, input int c);
        exp_t e;
        e.kind = kind;
        e.dat  = dat;
        e.addr = addr;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Reference model: frame accepted in cycle t0 -> expected strobes/response with their cycles
    task automatic model(input logic [31:0] f, input int t0);
        int b0, b1, b2, b3, code, addr;
        b0 = int'(f[7:0]);
        b1 = int'(f[15:8]);
        b2 = int'(f[23:16]);
        b3 = int'(f[31:24]);
        if (b0 != int'(HDR))                 code = 1;
        else if ((b0 + b1 + b2) % 256 != b3) code = 2;
        else if ((b1 / 16) % 8 != 0)         code = 3;
        else                                 code = 0;
        addr = b1 % 16;
        if (code != 0) begin
            err_exp = sat_inc(err_exp);
            push_exp(2, {8'(code), NAKB}, 4'd0, t0 + 2);
        end else if (b1 >= 128) begin
            push_exp(0, {8'h00, 8'(b2)}, 4'(addr), t0 + 2);
            push_exp(2, {8'(b2), ACKB}, 4'd0, t0 + 3);
            shadow[addr] = 8'(b2);
        end else begin
            push_exp(1, 16'h0000, 4'(addr), t0 + 2);
            push_exp(2, {shadow[addr], ACKB}, 4'd0, t0 + 4);
        end
    endtask

    // Monitor: compares every strobe and accepted response against the scoreboard
    logic        prev_vld = 1'b0;
    logic [15:0] held     = '0;
    logic        unstable = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.reg_wr_en) begin
                if (q.size() == 0 || q[0].kind != 0) unexpected("wr_strobe");
                else begin
                    chk("wr_addr", 32'(bus.reg_wr_addr), 32'(q[0].addr));
                    chk("wr_data", 32'(bus.reg_wr_data), 32'(q[0].dat[7:0]));
                    chk("wr_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
            if (bus.reg_rd_en) begin
                if (q.size() == 0 || q[0].kind != 1) unexpected("rd_strobe");
                else begin
                    chk("rd_addr", 32'(bus.reg_rd_addr), 32'(q[0].addr));
                    chk("rd_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
            if (bus.resp_vld) begin
                if (!prev_vld) begin
                    held     = bus.resp_data;
                    unstable = 1'b0;
                    if (q.size() == 0 || q[0].kind != 2) unexpected("resp_vld");
                    else chk("resp_cycle", cyc, q[0].cyc);
                end else if (bus.resp_data !== held) begin
                    unstable = 1'b1;
                end
                if (bus.resp_rdy) begin
                    if (q.size() != 0 && q[0].kind == 2) begin
                        chk("resp_data", 32'(bus.resp_data), 32'(q[0].dat));
                        chk("resp_stable", 32'(unstable), 32'd0);
                        void'(q.pop_front());
                    end
                    done_cnt++;
                end
            end
            prev_vld = bus.resp_vld;
        end
    end

    // Presents a frame in cycle t0; optionally a second frame in t0+1, which must be dropped
    task automatic issue(input logic [31:0] f, input bit inj);
        @(posedge clk);
        #1;
        bus.in_data = f;
        bus.in_vld  = 1'b1;
        model(f, cyc);
        @(posedge clk);
        #1;
        if (inj) begin
            bus.in_data = $urandom;
            ovf_exp     = sat_inc(ovf_exp);
            @(posedge clk);
            #1;
        end
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", done_cnt, target);
            q.delete();
        end
    endtask

    task automatic run_frame(input logic [31:0] f, input bit inj);
        int target;
        target = done_cnt + 1;
        issue(f, inj);
        wait_done(target);
    endtask

    function automatic logic [31:0] gen();
        int         k;
        logic [7:0] b0, b1, b2, b3;
        k  = $urandom_range(0, 6);
        b0 = HDR;
        b1 = {1'($urandom), 3'b000, 4'($urandom)};
        b2 = 8'($urandom);
        if (k == 4) begin
            b0      = HDR ^ 8'($urandom_range(1, 255));
            b1[6:4] = 3'($urandom);
        end
        if (k == 5) b1[6:4] = 3'($urandom_range(1, 7));
        b3 = b0 + b1 + b2;
        if (k == 3 || (k == 5 && $urandom_range(0, 1) == 1)) b3 = b3 ^ 8'($urandom_range(1, 255));
        if (k == 6) return $urandom;
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        int          target;
        int          n;
        logic [31:0] f;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
        chk("rst_strobes", {30'd0, bus.reg_wr_en, bus.reg_rd_en}, 32'd0);
        rstn = 1'b1;

        // Directed write, read and error frames
        rdy_mode = 0;
        run_frame(32'h643C83A5, 1'b0);
        run_frame(32'hAA0005A5, 1'b0);
        run_frame(32'h003C83A5, 1'b0);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
        run_frame(32'h633C83A4, 1'b0);
        chk("err_cnt_two", 32'(err_cnt), 32'd2);

        // Held backpressure with a frame arriving during RESP
        rdy_mode = 2;
        target   = done_cnt + 1;
        issue(32'h643C83A5, 1'b0);
        chk("busy_in_check", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_resp_vld", 32'(bus.resp_vld), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        bus.in_data = 32'hAA0005A5;
        bus.in_vld  = 1'b1;
        ovf_exp     = sat_inc(ovf_exp);
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_resp_vld_held", 32'(bus.resp_vld), 32'd1);
        chk("bp_resp_data", 32'(bus.resp_data), 32'h3C5A);
        chk("bp_ovf_cnt", 32'(ovf_cnt), 32'd1);
        rdy_mode = 0;
        wait_done(target);

        // Frame presented in the cycle RESP hands back to IDLE is dropped
        target = done_cnt + 1;
        issue(32'h633C83A4, 1'b0);
        @(posedge clk);
        #1;
        bus.in_data = 32'h643C83A5;
        bus.in_vld  = 1'b1;
        ovf_exp     = sat_inc(ovf_exp);
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        wait_done(target);
        repeat (5) @(posedge clk);
        #1;
        chk("handoff_ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));
        chk("handoff_busy", 32'(busy), 32'd0);

        // Reset while a response is pending
        rdy_mode = 2;
        issue(32'h643C83A5, 1'b0);
        n = 0;
        while (!bus.resp_vld && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_resp_vld", 32'(bus.resp_vld), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_resp_vld", 32'(bus.resp_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        q.delete();
        err_exp  = 0;
        ovf_exp  = 0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_resp_vld", 32'(bus.resp_vld), 32'd0);
        run_frame(32'hAA0005A5, 1'b0);

        // Random traffic with random backpressure and dropped frames
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            f = gen();
            run_frame(f, ($urandom_range(0, 3) == 0));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rand_err_cnt", 32'(err_cnt), 32'(err_exp));
        chk("rand_ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));

        // Saturation of the NAK counter
        rdy_mode = 0;
        for (int i = 0; i < 260; i++) begin
            f      = $urandom;
            f[7:0] = HDR ^ 8'($urandom_range(1, 255));
            run_frame(f, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, meaning the required value of frame byte 0.
REQ-002 SHALL have parameter ACK, default 8'h5A, meaning the status byte for a good frame.
REQ-003 SHALL have parameter NAK, default 8'hEE, meaning the status byte for a bad frame.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  32  received 4-byte frame; byte0 = [7:0] is received first.
REQ-007 SHALL have port in_vld  input  1  one-cycle strobe marking in_data valid.
REQ-008 SHALL have port reg_wr_en  output  1  register write strobe.
REQ-009 SHALL have port reg_wr_addr  output  4  register write address.
REQ-010 SHALL have port reg_wr_data  output  8  register write data.
REQ-011 SHALL have port reg_rd_en  output  1  register read strobe.
REQ-012 SHALL have port reg_rd_addr  output  4  register read address.
REQ-013 SHALL have port reg_rd_data  input  8  read data, valid the cycle after reg_rd_en.
REQ-014 SHALL have port resp_data  output  16  response word: [7:0] = status, [15:8] = payload; low byte is transmitted first.
REQ-015 SHALL have port resp_vld  output  1  response valid.
REQ-016 SHALL have port resp_rdy  input  1  downstream transmitter ready.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 SHALL have port err_cnt  output  8  saturating count of NAK responses.
REQ-019 SHALL have port ovf_cnt  output  8  saturating count of frames dropped while busy.

Function
REQ-020 SHALL decode the frame as: b0 = header; b1[7] = write(1)/read(0); b1[6:4] = reserved, must be 0; b1[3:0] = address; b2 = write data; b3 = checksum = (b0 + b1 + b2) mod 256.
REQ-021 SHALL implement FSM states IDLE, CHECK, WRITE, RDREQ, RDWAIT, RESP.
REQ-022 SHALL, in IDLE on in_vld, latch in_data and go to CHECK on the next edge.
REQ-023 SHALL, in CHECK, apply error priority header (code 8'h01) > checksum (8'h02) > reserved bits (8'h03).
REQ-024 SHALL, in CHECK, go to RESP with NAK on any error, otherwise to WRITE for a write or RDREQ for a read.
REQ-025 SHALL assert reg_wr_en for exactly the one cycle in WRITE, with reg_wr_addr = b1[3:0] and reg_wr_data = b2, then go to RESP with payload b2.
REQ-026 SHALL assert reg_rd_en for exactly the one cycle in RDREQ with reg_rd_addr = b1[3:0], then go to RDWAIT.
REQ-027 SHALL, in RDWAIT, capture reg_rd_data as the payload and go to RESP.
REQ-028 SHALL hold resp_vld high throughout RESP, with resp_data stable.
REQ-029 SHALL leave RESP to IDLE on the edge where resp_vld and resp_rdy are both high.
REQ-030 SHALL, for a NAK, output resp_data = {error code, NAK}; for an ACK, output {payload, ACK}.
REQ-031 SHALL meet these latencies, with in_vld at cycle 0: error -> resp_vld at cycle 2; write -> reg_wr_en at cycle 2 and resp_vld at cycle 3; read -> reg_rd_en at cycle 2 and resp_vld at cycle 4.
REQ-032 SHALL, when in_vld arrives in any state other than IDLE, drop the frame without disturbing the latched frame and increment ovf_cnt.
REQ-033 SHALL NOT accept a frame in the same cycle the FSM returns from RESP to IDLE; such a frame counts as dropped.
REQ-034 SHALL increment err_cnt by 1 on entering RESP with NAK.
REQ-035 SHALL saturate err_cnt and ovf_cnt at 8'hFF without wrapping.
REQ-036 SHALL deassert reg_wr_en, reg_rd_en and resp_vld in all states other than the ones defined above.

Reset
REQ-037 SHALL, on rstn low, asynchronously force state IDLE and all outputs and counters to 0, including mid-transaction.
REQ-038 SHALL discard any pending response on reset and produce no write or read strobe after rstn is released.

Verification
REQ-039 SHALL verify a write: in_data = 32'h643C83A5 -> reg_wr_en at cycle 2 with addr 4'h3 and data 8'h3C, then resp_data = 16'h3C5A at cycle 3.
REQ-040 SHALL verify a read: in_data = 32'hAA0005A5 and the bench returns 8'h77 -> reg_rd_en at cycle 2 with addr 4'h5, then resp_data = 16'h775A at cycle 4.
REQ-041 SHALL verify frame errors: in_data = 32'h003C83A5 -> resp_data = 16'h02EE, err_cnt = 1, no strobes; in_data = 32'h633C83A4 -> resp_data = 16'h01EE.
REQ-042 SHALL verify backpressure: resp_rdy held low for 10 cycles -> resp_vld stays high with resp_data stable; a second in_vld during that time -> ovf_cnt = 1 and the original response is unchanged.
REQ-043 SHALL verify reset: rstn pulsed low during RESP -> resp_vld = 0 and busy = 0 immediately, counters = 0, and the next valid frame is processed normally.
REQ-044 SHALL verify saturation: 260 bad frames -> err_cnt = 8'hFF.
